mmio_clint: RTL and testbench

Parametrised CLINT-style timer and software-interrupt block for multi-hart builds, attached to the data-side MMIO bus alongside the UART and FIFO registers. It provides a shared 64-bit mtime counter with a programmable prescaler and enable, plus one mtimecmp and one msip register per hart. It also provides a tear-free mtime high-word snapshot. Unlike the single-hart timer, it honours byte write enables.

---
 rtl/mmio_clint.sv | 234 +++++++++++++++++++++++
 tb/tb_mmio_clint.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_clint.sv
// ---------------------------------------------------------------------------
// mmio_clint
//
// CLINT-style timer / software-interrupt block on the data-side MMIO bus.
// A shared 64-bit mtime counter advances by TIMER_INCREMENT on every
// prescaler tick.  Each hart owns one 64-bit mtimecmp and one msip bit.
// Reading MTIME_LO captures the matching high word into a shadow register,
// which is read back through MTIME_HI_SNAP for a tear-free 64-bit read.
// All writes honour the per-byte write enables.
//
// Register window (byte offsets from BASE_ADDR, 4 KiB):
//   0x000 MTIME_LO       0x004 MTIME_HI      0x008 MTIME_HI_SNAP (RO)
//   0x00C CTRL           bit0 EN (reset 1), bits[31:16] DIV (reset 0)
//   0x100+8h MTIMECMP_LO[h]   0x104+8h MTIMECMP_HI[h]
//   0x200+4h MSIP[h]     bit0 only
//   Anything else reads 0 and ignores writes, but still reports a hit.
//
// Ports:
//   i_clk          clock
//   i_rst_n        synchronous active-low reset
//   i_addr         byte address (bits [1:0] ignored)
//   i_wr_data      write data
//   i_byte_wr_en   per-byte write enables, any bit set makes a write
//   i_rd_en        read strobe
//   o_rd_data      registered read data (0 when the previous cycle did not read)
//   o_hit          registered: previous-cycle access fell inside the window
//   o_mtip         per-hart timer interrupt pending (registered compare)
//   o_msip         per-hart software interrupt pending
//   o_mtime        current mtime for the time/timeh CSR view
// ---------------------------------------------------------------------------
module mmio_clint #(
    parameter logic [31:0] BASE_ADDR       = 32'h4000_0100,
    parameter int          NUM_HARTS       = 1,
    parameter logic [63:0] TIMER_INCREMENT = 64'd1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [31:0]          i_addr,
    input  logic [31:0]          i_wr_data,
    input  logic [3:0]           i_byte_wr_en,
    input  logic                 i_rd_en,
    output logic [31:0]          o_rd_data,
    output logic                 o_hit,
    output logic [NUM_HARTS-1:0] o_mtip,
    output logic [NUM_HARTS-1:0] o_msip,
    output logic [63:0]          o_mtime
);

    // Replace the byte lanes of old_word selected by be with new_word.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return res;
    endfunction

    // -----------------------------------------------------------------------
    // Address decode
    // -----------------------------------------------------------------------
    logic        in_win;
    logic        wr;
    logic        rd;
    logic [11:0] off;
    logic        sel_lo, sel_hi, sel_snap, sel_ctrl, sel_cmp, sel_msip;
    logic [4:0]  cmp_idx;
    logic        cmp_word_hi;
    logic [5:0]  msip_idx;

    // Low 12 bits of BASE_ADDR are masked so the window is always 4 KiB aligned.
    assign in_win      = ((i_addr & ~32'hFFF) == (BASE_ADDR & ~32'hFFF));
    assign off         = {i_addr[11:2], 2'b00};
    assign wr          = in_win && (i_byte_wr_en != 4'b0000);
    assign rd          = in_win && i_rd_en;

    assign sel_lo      = (off == 12'h000);
    assign sel_hi      = (off == 12'h004);
    assign sel_snap    = (off == 12'h008);
    assign sel_ctrl    = (off == 12'h00C);
    assign sel_cmp     = (off[11:8] == 4'h1);
    assign sel_msip    = (off[11:8] == 4'h2);
    assign cmp_idx     = off[7:3];
    assign cmp_word_hi = off[2];
    assign msip_idx    = off[7:2];

    // -----------------------------------------------------------------------
    // Shared state
    // -----------------------------------------------------------------------
    logic [63:0] mtime_reg, mtime_next;
    logic [31:0] shadow_reg;
    logic        en_reg;
    logic [15:0] div_reg;
    logic [15:0] pcnt_reg, pcnt_next;
    logic [31:0] rd_data_reg, rd_mux;
    logic        hit_reg;
    logic        tick;
    logic        ctrl_we;

    logic [63:0]          cmp_all [NUM_HARTS];
    logic [NUM_HARTS-1:0] msip_all;
    logic [NUM_HARTS-1:0] mtip_all;

    assign ctrl_we = wr && sel_ctrl;
    assign tick    = en_reg && (pcnt_reg == div_reg);

    // Prescaler: a CTRL write restarts the count; EN=0 freezes it.
    always_comb begin
        pcnt_next = pcnt_reg;
        if (ctrl_we) begin
            pcnt_next = 16'd0;
        end else if (en_reg) begin
            pcnt_next = tick ? 16'd0 : pcnt_reg + 16'd1;
        end
    end

    // A software write to either mtime word swallows that cycle's tick;
    // the untouched bytes keep their pre-write value.
    always_comb begin
        mtime_next = mtime_reg;
        if (wr && sel_lo) begin
            mtime_next[31:0] = merge_bytes(mtime_reg[31:0], i_wr_data, i_byte_wr_en);
        end else if (wr && sel_hi) begin
            mtime_next[63:32] = merge_bytes(mtime_reg[63:32], i_wr_data, i_byte_wr_en);
        end else if (tick) begin
            mtime_next = mtime_reg + TIMER_INCREMENT;
        end
    end

    // Read mux sees only pre-edge state, giving read-before-write behaviour.
    always_comb begin
        rd_mux = 32'd0;
        if (sel_lo) begin
            rd_mux = mtime_reg[31:0];
        end else if (sel_hi) begin
            rd_mux = mtime_reg[63:32];
        end else if (sel_snap) begin
            rd_mux = shadow_reg;
        end else if (sel_ctrl) begin
            rd_mux = {div_reg, 15'd0, en_reg};
        end else if (sel_cmp) begin
            for (int h = 0; h < NUM_HARTS; h++) begin
                if (cmp_idx == 5'(h)) begin
                    rd_mux = cmp_word_hi ? cmp_all[h][63:32] : cmp_all[h][31:0];
                end
            end
        end else if (sel_msip) begin
            for (int h = 0; h < NUM_HARTS; h++) begin
                if (msip_idx == 6'(h)) begin
                    rd_mux = {31'd0, msip_all[h]};
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            mtime_reg   <= 64'd0;
            shadow_reg  <= 32'd0;
            en_reg      <= 1'b1;
            div_reg     <= 16'd0;
            pcnt_reg    <= 16'd0;
            rd_data_reg <= 32'd0;
            hit_reg     <= 1'b0;
        end else begin
            mtime_reg <= mtime_next;
            pcnt_reg  <= pcnt_next;
            if (ctrl_we) begin
                if (i_byte_wr_en[0]) en_reg        <= i_wr_data[0];
                if (i_byte_wr_en[2]) div_reg[7:0]  <= i_wr_data[23:16];
                if (i_byte_wr_en[3]) div_reg[15:8] <= i_wr_data[31:24];
            end
            // Snapshot the high word alongside a MTIME_LO read.
            if (rd && sel_lo) begin
                shadow_reg <= mtime_reg[63:32];
            end
            rd_data_reg <= rd ? rd_mux : 32'd0;
            hit_reg     <= rd || wr;
        end
    end

    // -----------------------------------------------------------------------
    // Per-hart compare, software interrupt and timer interrupt
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_HARTS; gi++) begin : g_hart
            logic [63:0] cmp_reg;
            logic        msip_reg;
            logic        mtip_reg;
            logic        cmp_sel;
            logic        msip_sel;

            assign cmp_sel  = wr && sel_cmp  && (cmp_idx  == 5'(gi));
            assign msip_sel = wr && sel_msip && (msip_idx == 6'(gi));

            always_ff @(posedge i_clk) begin
                if (!i_rst_n) begin
                    cmp_reg  <= '1;
                    msip_reg <= 1'b0;
                    mtip_reg <= 1'b0;
                end else begin
                    if (cmp_sel && !cmp_word_hi) begin
                        cmp_reg[31:0] <= merge_bytes(cmp_reg[31:0], i_wr_data, i_byte_wr_en);
                    end
                    if (cmp_sel && cmp_word_hi) begin
                        cmp_reg[63:32] <= merge_bytes(cmp_reg[63:32], i_wr_data, i_byte_wr_en);
                    end
                    if (msip_sel && i_byte_wr_en[0]) begin
                        msip_reg <= i_wr_data[0];
                    end
                    // Compare registered values, so a new mtime/mtimecmp shows
                    // up on o_mtip one edge after it lands.
                    mtip_reg <= (mtime_reg >= cmp_reg);
                end
            end

            assign cmp_all[gi]  = cmp_reg;
            assign msip_all[gi] = msip_reg;
            assign mtip_all[gi] = mtip_reg;
        end
    endgenerate

    assign o_rd_data = rd_data_reg;
    assign o_hit     = hit_reg;
    assign o_mtip    = mtip_all;
    assign o_msip    = msip_all;
    assign o_mtime   = mtime_reg;

endmodule

// File: tb/tb_mmio_clint.sv
// ---------------------------------------------------------------------------
// tb_mmio_clint: directed scenarios plus randomized bus traffic, all checked
// against a transaction-level reference model of the register file.
// ---------------------------------------------------------------------------
module tb_mmio_clint;

    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam int          NH   = 4;
    localparam logic [63:0] INC  = 64'd1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   addr = 32'd0;
    logic [31:0]   wdata = 32'd0;
    logic [3:0]    be = 4'd0;
    logic          rd_en = 1'b0;
    logic [31:0]   o_rd_data;
    logic          o_hit;
    logic [NH-1:0] o_mtip;
    logic [NH-1:0] o_msip;
    logic [63:0]   o_mtime;

    mmio_clint #(
        .BASE_ADDR      (BASE),
        .NUM_HARTS      (NH),
        .TIMER_INCREMENT(INC)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_addr      (addr),
        .i_wr_data   (wdata),
        .i_byte_wr_en(be),
        .i_rd_en     (rd_en),
        .o_rd_data   (o_rd_data),
        .o_hit       (o_hit),
        .o_mtip      (o_mtip),
        .o_msip      (o_msip),
        .o_mtime     (o_mtime)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [63:0]   m_mtime;
    logic [63:0]   m_cmp [NH];
    logic [NH-1:0] m_msip;
    logic          m_en;
    logic [15:0]   m_div;
    logic [15:0]   m_pcnt;
    logic [31:0]   m_shadow;
    logic [31:0]   exp_rd;
    logic          exp_hit;
    logic [NH-1:0] exp_mtip;

    function automatic logic [31:0] lane_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                               input logic [3:0] b);
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = new_w[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_read(input int off);
        if (off == 0)  return m_mtime[31:0];
        if (off == 4)  return m_mtime[63:32];
        if (off == 8)  return m_shadow;
        if (off == 12) return {m_div, 15'd0, m_en};
        if (off >= 256 && off < 256 + 8 * NH)
            return (off % 8 == 0) ? m_cmp[(off - 256) / 8][31:0] : m_cmp[(off - 256) / 8][63:32];
        if (off >= 512 && off < 512 + 4 * NH)
            return {31'd0, m_msip[(off - 512) / 4]};
        return 32'd0;
    endfunction

    task automatic model_step(input logic r, input logic [31:0] a, input logic [31:0] wd,
                              input logic [3:0] b, input logic re);
        logic in_win, wr, rdv, tick;
        logic [31:0] w;
        int off, h;
        if (!r) begin
            m_mtime = 64'd0; m_msip = '0; m_en = 1'b1; m_div = 16'd0; m_pcnt = 16'd0;
            m_shadow = 32'd0;
            for (int k = 0; k < NH; k++) m_cmp[k] = '1;
            exp_rd = 32'd0; exp_hit = 1'b0; exp_mtip = '0;
            return;
        end
        in_win = ((a & ~32'hFFF) == BASE);
        off    = int'(a[11:0]) & ~3;
        wr     = in_win && (b != 4'd0);
        rdv    = in_win && re;
        exp_rd  = rdv ? model_read(off) : 32'd0;
        exp_hit = rdv || wr;
        for (int k = 0; k < NH; k++) exp_mtip[k] = (m_mtime >= m_cmp[k]);
        tick = m_en && (m_pcnt == m_div);
        if (rdv && off == 0) m_shadow = m_mtime[63:32];
        if (wr && off == 12) begin
            w = lane_merge({m_div, 15'd0, m_en}, wd, b);
            m_en = w[0]; m_div = w[31:16]; m_pcnt = 16'd0;
        end else if (m_en) begin
            m_pcnt = tick ? 16'd0 : m_pcnt + 16'd1;
        end
        if (wr && off == 0)      m_mtime[31:0]  = lane_merge(m_mtime[31:0], wd, b);
        else if (wr && off == 4) m_mtime[63:32] = lane_merge(m_mtime[63:32], wd, b);
        else if (tick)           m_mtime        = m_mtime + INC;
        if (wr && off >= 256 && off < 256 + 8 * NH) begin
            h = (off - 256) / 8;
            if (off % 8 == 0) m_cmp[h][31:0]  = lane_merge(m_cmp[h][31:0], wd, b);
            else              m_cmp[h][63:32] = lane_merge(m_cmp[h][63:32], wd, b);
        end
        if (wr && off >= 512 && off < 512 + 4 * NH) begin
            h = (off - 512) / 4;
            w = lane_merge({31'd0, m_msip[h]}, wd, b);
            m_msip[h] = w[0];
        end
    endtask

    // One bus cycle: drive, clock, update model, check every output.
    task automatic cyc(input logic r, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] b, input logic re);
        rst_n = r; addr = a; wdata = wd; be = b; rd_en = re;
        @(posedge clk);
        model_step(r, a, wd, b, re);
        #1;
        check_val("rd_data", {32'd0, o_rd_data}, {32'd0, exp_rd});
        check_val("hit", {63'd0, o_hit}, {63'd0, exp_hit});
        check_val("mtip", {60'd0, o_mtip}, {60'd0, exp_mtip});
        check_val("msip", {60'd0, o_msip}, {60'd0, m_msip});
        check_val("mtime", o_mtime, m_mtime);
        if (re || b != 4'd0 || !r)
            $display("txn rst_n=%0b addr=%08h wdata=%08h be=%b rd=%0b -> rd_data=%08h hit=%0b mtip=%b msip=%b",
                     r, a, wd, b, re, o_rd_data, o_hit, o_mtip, o_msip);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 32'd0, 32'd0, 4'd0, 1'b0);
    endtask

    task automatic wr32(input int off, input logic [31:0] d, input logic [3:0] b);
        cyc(1'b1, BASE + 32'(off), d, b, 1'b0);
    endtask

    task automatic rd32(input int off);
        cyc(1'b1, BASE + 32'(off), 32'd0, 4'd0, 1'b1);
    endtask

    int offs [22] = '{'h000, 'h004, 'h008, 'h00C, 'h010, 'h100, 'h104, 'h108, 'h10C, 'h110,
                      'h114, 'h118, 'h11C, 'h120, 'h1F8, 'h200, 'h204, 'h208, 'h20C, 'h210,
                      'h300, 'hFFC};

    initial begin
        logic [63:0] base_t;
        logic [15:0] target;
        logic [31:0] a, d;
        logic [3:0]  b;
        int          sel;

        // Reset and free-running count
        cyc(1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
        cyc(1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
        idle(10);
        rd32('h000);
        check_val("mtime_after_10", {32'd0, o_rd_data}, 64'd10);
        check_val("mtip_idle", {60'd0, o_mtip}, 64'd0);
        for (int h = 0; h < NH; h++) begin
            rd32('h100 + 8 * h);
            check_val("cmp_lo_reset", {32'd0, o_rd_data}, 64'hFFFF_FFFF);
            rd32('h104 + 8 * h);
            check_val("cmp_hi_reset", {32'd0, o_rd_data}, 64'hFFFF_FFFF);
        end

        // Prescaler DIV=3, then EN=0
        wr32('h00C, 32'h0003_0001, 4'hF);
        base_t = o_mtime;
        idle(40);
        check_val("div3_ticks", o_mtime - base_t, 64'd10);
        wr32('h00C, 32'h0000_0000, 4'hF);
        base_t = o_mtime;
        idle(100);
        check_val("en0_frozen", o_mtime, base_t);

        // Carry into the high word and the snapshot
        wr32('h00C, 32'h0000_0001, 4'hF);
        wr32('h004, 32'h0, 4'hF);
        wr32('h000, 32'hFFFF_FFFF, 4'hF);
        idle(1);
        rd32('h004);
        check_val("carry_hi", {32'd0, o_rd_data}, 64'd1);
        rd32('h000);
        rd32('h008);
        check_val("snap_hi", {32'd0, o_rd_data}, 64'd1);

        // Wrap of the full 64-bit counter
        wr32('h000, 32'hFFFF_FFFF, 4'hF);
        wr32('h004, 32'hFFFF_FFFF, 4'hF);
        check_val("all_ones", o_mtime, 64'hFFFF_FFFF_FFFF_FFFF);
        idle(1);
        check_val("wrap_zero", o_mtime, 64'd0);

        // Hart 2 compare with partial byte enables
        wr32('h110, 32'h0000_FFFF, 4'hF);
        wr32('h114, 32'h0, 4'hF);
        target = o_mtime[15:0] + 16'd20;
        wr32('h110, {16'hABCD, target}, 4'b0011);
        rd32('h110);
        check_val("cmp2_partial", {32'd0, o_rd_data}, {48'd0, target});
        for (int i = 0; i < 60 && !o_mtip[2]; i++) idle(1);
        check_val("mtip2_rise", {63'd0, o_mtip[2]}, 64'd1);
        check_val("mtip_others", {60'd0, o_mtip & 4'b1011}, 64'd0);

        // Software interrupts and decode edges
        wr32('h204, 32'h5, 4'hF);
        check_val("msip_set", {60'd0, o_msip}, 64'b0010);
        rd32('h204);
        check_val("msip_read", {32'd0, o_rd_data}, 64'd1);
        wr32('h210, 32'h1, 4'hF);
        rd32('h210);
        check_val("hart4_read", {32'd0, o_rd_data}, 64'd0);
        check_val("hart4_hit", {63'd0, o_hit}, 64'd1);
        cyc(1'b1, 32'h5000_0000, 32'd0, 4'd0, 1'b1);
        check_val("outside_hit", {63'd0, o_hit}, 64'd0);

        // Reset wins over a coincident compare write
        cyc(1'b0, BASE + 32'h100, 32'h0, 4'hF, 1'b0);
        check_val("rst_mtip", {60'd0, o_mtip}, 64'd0);
        rd32('h100);
        check_val("rst_cmp0", {32'd0, o_rd_data}, 64'hFFFF_FFFF);

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            sel = int'($urandom_range(0, 21));
            a = ($urandom_range(0, 15) == 0) ? (32'h5000_0000 | 32'(offs[sel])) : BASE + 32'(offs[sel]);
            b = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
            case ($urandom_range(0, 2))
                0:       d = $urandom;
                1:       d = 32'($urandom_range(0, 64));
                default: d = 32'hFFFF_FFFF;
            endcase
            if (offs[sel] == 'h00C) d = d & 32'h0007_0001 | 32'($urandom_range(0, 1));
            cyc(($urandom_range(0, 299) != 0), a, d, b, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
